// File: rtl/nt_update_scheduler.sv
// Four-channel neurotransmitter level scheduler: a periodic tick launches a
// 4-slot round-robin sweep that applies saturating inc/dec/set updates.
module nt_update_scheduler #(
    parameter int unsigned N           = 7,
    parameter int unsigned DIV         = 8,
    parameter int unsigned FAST_STEP   = 3,
    parameter int unsigned SET_VAL     = 64,
    parameter int unsigned DEFAULT_VAL = 96
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [3:0]     inc,
    input  logic [3:0]     dec,
    input  logic [3:0]     fast,
    input  logic [3:0]     setval,
    output logic [4*N-1:0] levels,
    output logic [7:0]     levels_2b,
    output logic [3:0]     grant,
    output logic           busy,
    output logic           overrun
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    ptr, ptr_nxt;
    logic [1:0]    slot, slot_nxt;
    logic          pending, pending_nxt;
    logic          overrun_nxt;
    logic          tick;

    logic [N-1:0]  lvl [4];
    logic [1:0]    ch;
    logic          req;
    logic          wr;
    logic          sub;
    logic [N-1:0]  step;
    logic [N-1:0]  cur;
    logic [N:0]    sum;
    logic [N-1:0]  sat;
    logic [N-1:0]  upd;

    // Free-running tick divider, frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            slot    <= 2'd0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            slot    <= slot_nxt;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
        end
    end

    // A tick in slot 3 with pending already set is dropped; re-entry consumes pending
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        slot_nxt    = slot;
        pending_nxt = pending;
        overrun_nxt = overrun;
        case (state)
            IDLE: begin
                if (tick || pending) begin
                    state_nxt   = SWEEP;
                    slot_nxt    = 2'd0;
                    pending_nxt = 1'b0;
                end
            end
            SWEEP: begin
                if (tick) begin
                    if (pending) begin
                        overrun_nxt = 1'b1;
                    end else begin
                        pending_nxt = 1'b1;
                    end
                end
                if (slot == 2'd3) begin
                    ptr_nxt  = ptr + 2'd1;
                    slot_nxt = 2'd0;
                    if (pending) begin
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    slot_nxt = slot + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == SWEEP);
    assign ch    = ptr + slot;
    assign req   = inc[ch] | dec[ch] | setval[ch];
    assign wr    = busy && req;
    assign grant = wr ? (4'b0001 << ch) : 4'b0000;

    // Shared adder: subtraction as add of ones-complement plus carry-in; bit N flags over/underflow
    assign cur  = lvl[ch];
    assign sub  = dec[ch] & ~inc[ch];
    assign step = fast[ch] ? N'(FAST_STEP) : N'(1);
    assign sum  = {1'b0, cur} + (sub ? ~{1'b0, step} : {1'b0, step}) + (N+1)'(sub);
    assign sat  = sum[N] ? (sub ? '0 : '1) : sum[N-1:0];

    always_comb begin
        upd = cur;
        if (setval[ch]) begin
            upd = N'(SET_VAL);
        end else if (inc[ch] && dec[ch]) begin
            upd = cur;
        end else if (inc[ch] || dec[ch]) begin
            upd = sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                lvl[i] <= N'(DEFAULT_VAL);
            end
        end else if (wr) begin
            lvl[ch] <= upd;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign levels[N*g +: N]     = lvl[g];
        assign levels_2b[2*g +: 2] = lvl[g][N-1 -: 2];
    end

endmodule

// File: tb/tb_nt_update_scheduler.sv
// Directed bench for nt_update_scheduler: default instance plus a DIV=2 instance for overrun.
module tb_nt_update_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  inc = 4'h0;
    logic [3:0]  dec = 4'h0;
    logic [3:0]  fast = 4'h0;
    logic [3:0]  setval = 4'h0;

    logic [27:0] levels;
    logic [7:0]  levels_2b;
    logic [3:0]  grant;
    logic        busy;
    logic        overrun;

    logic [27:0] levels_d2;
    logic [7:0]  levels_2b_d2;
    logic [3:0]  grant_d2;
    logic        busy_d2;
    logic        overrun_d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nt_update_scheduler u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .inc(inc), .dec(dec), .fast(fast), .setval(setval),
        .levels(levels), .levels_2b(levels_2b), .grant(grant),
        .busy(busy), .overrun(overrun)
    );

    nt_update_scheduler #(.DIV(2)) u_dut_div2 (
        .clk(clk), .rst(rst), .enable(enable),
        .inc(inc), .dec(dec), .fast(fast), .setval(setval),
        .levels(levels_d2), .levels_2b(levels_2b_d2), .grant(grant_d2),
        .busy(busy_d2), .overrun(overrun_d2)
    );

    function automatic logic [6:0] lvl(input int i);
        return levels[7*i +: 7];
    endfunction

    task automatic step_cycle;
        @(posedge clk);
        #1;
    endtask

    // Advance until busy reaches val; running out of cycles is reported as a failure
    task automatic wait_busy(input logic val);
        int n;
        n = 0;
        while (busy !== val && n < 300) begin
            step_cycle();
            n++;
        end
        if (busy !== val) begin
            checks++;
            errors++;
            $display("FAIL wait_busy: busy=%b required %b after %0d cycles", busy, val, n);
        end
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        enable = 1'b0;
        inc    = 4'h0;
        dec    = 4'h0;
        fast   = 4'h0;
        setval = 4'h0;
        step_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (levels !== {4{7'd96}}) begin errors++; $display("FAIL reset_levels: got %h expected %h", levels, {4{7'd96}}); end
        checks++;
        if (levels_2b !== 8'hFF) begin errors++; $display("FAIL reset_levels_2b: got %h expected ff", levels_2b); end
        checks++;
        if (grant !== 4'h0) begin errors++; $display("FAIL reset_grant: got %h expected 0", grant); end
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_busy_overrun: got %b%b expected 00", busy, overrun); end
        rst = 1'b0;
    endtask

    task automatic test_idle_sweeps;
        logic exp_busy;
        do_reset();
        enable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step_cycle();
            exp_busy = (c >= 8) && ((c % 8) < 4);
            checks++;
            if (busy !== exp_busy) begin errors++; $display("FAIL idle_busy cycle %0d: got %b expected %b", c, busy, exp_busy); end
            checks++;
            if (grant !== 4'h0) begin errors++; $display("FAIL idle_grant cycle %0d: got %h expected 0", c, grant); end
        end
        checks++;
        if (levels !== {4{7'd96}} || levels_2b !== 8'hFF) begin
            errors++; $display("FAIL idle_levels: got %h/%h expected %h/ff", levels, levels_2b, {4{7'd96}});
        end
    endtask

    task automatic test_inc_fast_sat;
        int exp_v;
        do_reset();
        inc    = 4'b0001;
        fast   = 4'b0001;
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            wait_busy(1'b1);
            wait_busy(1'b0);
            exp_v = 96 + 3 * k;
            if (exp_v > 127) exp_v = 127;
            checks++;
            if (lvl(0) !== 7'(exp_v)) begin errors++; $display("FAIL inc_fast sweep %0d: got %0d expected %0d", k, lvl(0), exp_v); end
        end
        checks++;
        if (lvl(1) !== 7'd96 || lvl(3) !== 7'd96) begin errors++; $display("FAIL inc_fast_others: got %0d,%0d expected 96,96", lvl(1), lvl(3)); end
    endtask

    task automatic test_dec_sat;
        int exp_v;
        do_reset();
        setval = 4'b0100;
        enable = 1'b1;
        wait_busy(1'b1);
        wait_busy(1'b0);
        checks++;
        if (lvl(2) !== 7'd64) begin errors++; $display("FAIL dec_setval: got %0d expected 64", lvl(2)); end
        setval = 4'b0000;
        dec    = 4'b0100;
        fast   = 4'b0100;
        for (int k = 1; k <= 23; k++) begin
            wait_busy(1'b1);
            wait_busy(1'b0);
            exp_v = 64 - 3 * k;
            if (exp_v < 0) exp_v = 0;
            checks++;
            if (lvl(2) !== 7'(exp_v)) begin errors++; $display("FAIL dec_fast sweep %0d: got %0d expected %0d", k, lvl(2), exp_v); end
        end
    endtask

    task automatic test_inc_dec_setval;
        do_reset();
        inc    = 4'b0010;
        dec    = 4'b0010;
        enable = 1'b1;
        wait_busy(1'b1);
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL incdec_slot0_grant: got %b expected 0000", grant); end
        step_cycle();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL incdec_slot1_grant: got %b expected 0010", grant); end
        step_cycle();
        checks++;
        if (lvl(1) !== 7'd96) begin errors++; $display("FAIL incdec_level: got %0d expected 96", lvl(1)); end
        wait_busy(1'b0);
        setval = 4'b0010;
        wait_busy(1'b1);
        checks++;
        if (grant !== 4'b0010 || lvl(1) !== 7'd96) begin
            errors++; $display("FAIL setval_grant_cycle: grant %b level %0d expected 0010 96", grant, lvl(1));
        end
        step_cycle();
        checks++;
        if (lvl(1) !== 7'd64) begin errors++; $display("FAIL setval_level: got %0d expected 64", lvl(1)); end
        checks++;
        if (levels_2b !== 8'hFB) begin errors++; $display("FAIL setval_levels_2b: got %h expected fb", levels_2b); end
    endtask

    task automatic test_rotation;
        logic [3:0] exp_g [12] = '{4'h1, 4'h2, 4'h4, 4'h8,
                                   4'h2, 4'h4, 4'h8, 4'h1,
                                   4'h4, 4'h8, 4'h1, 4'h2};
        do_reset();
        inc    = 4'hF;
        enable = 1'b1;
        for (int s = 0; s < 3; s++) begin
            wait_busy(1'b0);
            wait_busy(1'b1);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) step_cycle();
                checks++;
                if (grant !== exp_g[4*s+k]) begin
                    errors++; $display("FAIL rotation sweep %0d slot %0d: got %b expected %b", s, k, grant, exp_g[4*s+k]);
                end
            end
        end
        step_cycle();
        checks++;
        if (levels !== {4{7'd99}}) begin errors++; $display("FAIL rotation_levels: got %h expected %h", levels, {4{7'd99}}); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        enable = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step_cycle();
            if (c == 1) begin
                checks++;
                if (busy_d2 !== 1'b0) begin errors++; $display("FAIL b2b_busy cycle 1: got %b expected 0", busy_d2); end
            end
            if (c >= 2) begin
                checks++;
                if (busy_d2 !== 1'b1) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b expected 1", c, busy_d2); end
            end
            if (c == 5) begin
                checks++;
                if (overrun_d2 !== 1'b0) begin errors++; $display("FAIL b2b_overrun cycle 5: got %b expected 0", overrun_d2); end
            end
            if (c >= 6) begin
                checks++;
                if (overrun_d2 !== 1'b1) begin errors++; $display("FAIL b2b_overrun cycle %0d: got %b expected 1", c, overrun_d2); end
            end
        end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_default_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_reset_mid_sweep;
        do_reset();
        inc    = 4'hF;
        enable = 1'b1;
        wait_busy(1'b1);
        step_cycle();
        step_cycle();
        checks++;
        if (grant !== 4'b0100 || lvl(0) !== 7'd97) begin
            errors++; $display("FAIL midrst_slot2: grant %b level0 %0d expected 0100 97", grant, lvl(0));
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (levels !== {4{7'd96}}) begin errors++; $display("FAIL midrst_levels: got %h expected %h", levels, {4{7'd96}}); end
        checks++;
        if (busy !== 1'b0 || grant !== 4'h0) begin errors++; $display("FAIL midrst_busy_grant: got %b/%b expected 0/0000", busy, grant); end
        step_cycle();
        rst = 1'b0;
        wait_busy(1'b1);
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_restart_slot0: got %b expected 0001", grant); end
        step_cycle();
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL midrst_restart_slot1: got %b expected 0010", grant); end
    endtask

    initial begin
        test_reset();
        test_idle_sweeps();
        test_inc_fast_sat();
        test_dec_sat();
        test_inc_dec_setval();
        test_rotation();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
